// File: rtl/change_dispenser_pkg.sv
// Shared definitions for the change dispenser slice.
//   denom_e      : hopper denomination codes (0 = none, 1 = one, 2 = two, 3 = five)
//   VAL_*        : unit value of each denomination
//   state_e      : dispenser FSM states
//   denom_value  : maps a denomination code to its unit value
package change_dispenser_pkg;

  typedef enum logic [1:0] {
    DENOM_NONE = 2'd0,
    DENOM_1    = 2'd1,
    DENOM_2    = 2'd2,
    DENOM_5    = 2'd3
  } denom_e;

  localparam logic [7:0] VAL_1 = 8'd1;
  localparam logic [7:0] VAL_2 = 8'd2;
  localparam logic [7:0] VAL_5 = 8'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_EJECT,
    ST_GAP,
    ST_FINISH
  } state_e;

  function automatic logic [7:0] denom_value(input denom_e d);
    case (d)
      DENOM_1: denom_value = VAL_1;
      DENOM_2: denom_value = VAL_2;
      DENOM_5: denom_value = VAL_5;
      default: denom_value = '0;
    endcase
  endfunction

endpackage

// File: rtl/change_dispenser_gap_timer.sv
// Loadable down-counter with a zero flag.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val this cycle (takes priority over counting)
//   load_val   : value to load
//   zero       : counter currently at zero
// The counter decrements on every cycle it is non-zero and holds at zero.
module gap_timer
  import change_dispenser_pkg::*;
#(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: turns a credit amount into a greedy (5, 2, 1) sequence of
// coin ejections towards the hopper, tracking a finite tube per denomination.
//   clk, rst        : clock, asynchronous active-low reset
//   start, amount   : dispense request (amount sampled on acceptance in IDLE)
//   refill          : reload all tubes to TUBE_INIT (IDLE only)
//   eject_valid/eject_denom/eject_ready : registered handshake to the hopper
//   busy, done      : activity flag and single-cycle completion pulse
//   short_change    : amount left unpaid at done, held until the next start
//   remaining       : value still owed
//   tube5/tube2/tube1 : current tube levels
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 4,
  parameter int unsigned TUBE_W     = 4,
  parameter int unsigned TUBE_INIT  = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        amount,
  input  logic              refill,
  output logic              eject_valid,
  output logic [1:0]        eject_denom,
  input  logic              eject_ready,
  output logic              busy,
  output logic              done,
  output logic              short_change,
  output logic [7:0]        remaining,
  output logic [TUBE_W-1:0] tube5,
  output logic [TUBE_W-1:0] tube2,
  output logic [TUBE_W-1:0] tube1
);

  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  // Loading GAP_CYCLES-1 yields exactly GAP_CYCLES cycles spent in ST_GAP.
  localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [TUBE_W-1:0] TUBE_FULL = TUBE_W'(TUBE_INIT);

  state_e             state_q, state_d;
  logic               valid_q, valid_d;
  denom_e             denom_q, denom_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               short_q, short_d;
  logic [7:0]         rem_q, rem_d;
  logic [TUBE_W-1:0]  tube5_q, tube5_d;
  logic [TUBE_W-1:0]  tube2_q, tube2_d;
  logic [TUBE_W-1:0]  tube1_q, tube1_d;

  logic               gap_load;
  logic               gap_zero;
  denom_e             pick;

  gap_timer #(
    .W (GAP_W)
  ) u_gap_timer (
    .clk      (clk),
    .rst_n    (rst),
    .load     (gap_load),
    .load_val (GAP_LOAD),
    .zero     (gap_zero)
  );

  // Greedy choice: largest denomination that fits and is still stocked.
  always_comb begin
    pick = DENOM_NONE;
    if (rem_q >= VAL_5 && tube5_q != '0) begin
      pick = DENOM_5;
    end else if (rem_q >= VAL_2 && tube2_q != '0) begin
      pick = DENOM_2;
    end else if (rem_q >= VAL_1 && tube1_q != '0) begin
      pick = DENOM_1;
    end
  end

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    denom_d  = denom_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    short_d  = short_q;
    rem_d    = rem_q;
    tube5_d  = tube5_q;
    tube2_d  = tube2_q;
    tube1_d  = tube1_q;
    gap_load = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (refill) begin
          tube5_d = TUBE_FULL;
          tube2_d = TUBE_FULL;
          tube1_d = TUBE_FULL;
        end
        if (start) begin
          rem_d   = amount;
          short_d = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_SELECT;
        end
      end

      ST_SELECT: begin
        if (pick != DENOM_NONE) begin
          denom_d = pick;
          valid_d = 1'b1;
          state_d = ST_EJECT;
        end else begin
          // done is registered, so it is high for the whole FINISH cycle.
          done_d  = 1'b1;
          state_d = ST_FINISH;
        end
      end

      ST_EJECT: begin
        if (valid_q && eject_ready) begin
          rem_d = rem_q - denom_value(denom_q);
          case (denom_q)
            DENOM_5: tube5_d = (tube5_q != '0) ? tube5_q - TUBE_W'(1) : '0;
            DENOM_2: tube2_d = (tube2_q != '0) ? tube2_q - TUBE_W'(1) : '0;
            DENOM_1: tube1_d = (tube1_q != '0) ? tube1_q - TUBE_W'(1) : '0;
            default: ;
          endcase
          valid_d  = 1'b0;
          denom_d  = DENOM_NONE;
          gap_load = 1'b1;
          state_d  = ST_GAP;
        end
      end

      ST_GAP: begin
        if (gap_zero) begin
          state_d = ST_SELECT;
        end
      end

      ST_FINISH: begin
        short_d = (rem_q != '0);
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      denom_q <= DENOM_NONE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      short_q <= 1'b0;
      rem_q   <= '0;
      tube5_q <= TUBE_FULL;
      tube2_q <= TUBE_FULL;
      tube1_q <= TUBE_FULL;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      denom_q <= denom_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      short_q <= short_d;
      rem_q   <= rem_d;
      tube5_q <= tube5_d;
      tube2_q <= tube2_d;
      tube1_q <= tube1_d;
    end
  end

  assign eject_valid  = valid_q;
  assign eject_denom  = denom_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign short_change = short_q;
  assign remaining    = rem_q;
  assign tube5        = tube5_q;
  assign tube2        = tube2_q;
  assign tube1        = tube1_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed testbench for change_dispenser (GAP_CYCLES=4, TUBE_W=4, TUBE_INIT=15).
module tb_change_dispenser;

  localparam int unsigned GAP = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] amount = '0;
  logic       refill = 1'b0;
  logic       eject_ready = 1'b1;
  logic       eject_valid;
  logic [1:0] eject_denom;
  logic       busy, done, short_change;
  logic [7:0] remaining;
  logic [3:0] tube5, tube2, tube1;

  int chk_total = 0;
  int pass_cnt  = 0;

  // Results of the last watch_run
  logic [1:0] ej_log [0:31];
  int ej_cnt, n5, n2, n1, done_cnt, done_idx, busy_cycles, min_gap;
  logic timed_out;

  change_dispenser #(
    .GAP_CYCLES (GAP),
    .TUBE_W     (4),
    .TUBE_INIT  (15)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .amount       (amount),
    .refill       (refill),
    .eject_valid  (eject_valid),
    .eject_denom  (eject_denom),
    .eject_ready  (eject_ready),
    .busy         (busy),
    .done         (done),
    .short_change (short_change),
    .remaining    (remaining),
    .tube5        (tube5),
    .tube2        (tube2),
    .tube1        (tube1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_total++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issue a one-cycle start; returns #1 after the accepting edge (SELECT cycle).
  task automatic do_start(input logic [7:0] amt, input logic rf);
    @(posedge clk); #1;
    start  = 1'b1;
    amount = amt;
    refill = rf;
    @(posedge clk); #1;
    start  = 1'b0;
    refill = 1'b0;
  endtask

  // Observe one cycle at a time until done has come and gone, within budget.
  task automatic watch_run(input int budget);
    int  gap;
    logic seen;
    ej_cnt = 0; n5 = 0; n2 = 0; n1 = 0;
    done_cnt = 0; done_idx = -1; busy_cycles = 0;
    min_gap = 1000; gap = 0; seen = 1'b0; timed_out = 1'b1;
    for (int c = 0; c < budget; c++) begin
      if (done_cnt > 0 && !done) begin
        timed_out = 1'b0;
        break;
      end
      if (busy) busy_cycles++;
      if (eject_valid) begin
        if (seen && gap > 0 && gap < min_gap) min_gap = gap;
        gap  = 0;
        seen = 1'b1;
        if (eject_ready) begin
          if (ej_cnt < 32) ej_log[ej_cnt] = eject_denom;
          ej_cnt++;
          if (eject_denom == 2'd3) n5++;
          if (eject_denom == 2'd2) n2++;
          if (eject_denom == 2'd1) n1++;
        end
      end else begin
        gap++;
      end
      if (done) begin
        if (done_cnt == 0) done_idx = c;
        done_cnt++;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    // ---------------- reset ----------------
    #2;
    check("rst_async_valid", {31'd0, eject_valid}, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    check("rst_valid", {31'd0, eject_valid}, 0);
    check("rst_denom", {30'd0, eject_denom}, 0);
    check("rst_busy",  {31'd0, busy}, 0);
    check("rst_done",  {31'd0, done}, 0);
    check("rst_short", {31'd0, short_change}, 0);
    check("rst_rem",   {24'd0, remaining}, 0);
    check("rst_tubes", {20'd0, tube5, tube2, tube1}, 32'hFFF);

    // ---------------- amount=8, greedy 5,2,1 ----------------
    eject_ready = 1'b1;
    do_start(8'd8, 1'b0);
    check("a8_busy_sel", {31'd0, busy}, 1);
    check("a8_valid_sel", {31'd0, eject_valid}, 0);
    watch_run(200);
    check("a8_timeout", {31'd0, timed_out}, 0);
    check("a8_count", ej_cnt, 3);
    check("a8_first",  {30'd0, ej_log[0]}, 3);
    check("a8_second", {30'd0, ej_log[1]}, 2);
    check("a8_third",  {30'd0, ej_log[2]}, 1);
    check("a8_gap_ok", {31'd0, (min_gap >= GAP)}, 1);
    check("a8_done_once", done_cnt, 1);
    check("a8_rem", {24'd0, remaining}, 0);
    check("a8_short", {31'd0, short_change}, 0);
    check("a8_busy_end", {31'd0, busy}, 0);
    check("a8_tubes", {20'd0, tube5, tube2, tube1}, 32'hEEE);

    // ---------------- amount=0 ----------------
    do_start(8'd0, 1'b0);
    watch_run(50);
    check("a0_timeout", {31'd0, timed_out}, 0);
    check("a0_ejects", ej_cnt, 0);
    check("a0_done_idx", done_idx, 1);
    check("a0_done_once", done_cnt, 1);
    check("a0_busy_cycles", busy_cycles, 2);

    // ---------------- stall with ignored starts ----------------
    eject_ready = 1'b0;
    do_start(8'd5, 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      check("stall_hold", {29'd0, eject_valid, eject_denom}, 3'b111);
      start  = (i % 3 == 0);
      amount = 8'd9;
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("stall_busy", {31'd0, busy}, 1);
    check("stall_rem", {24'd0, remaining}, 5);
    eject_ready = 1'b1;
    watch_run(100);
    check("stall_timeout", {31'd0, timed_out}, 0);
    check("stall_ejects", ej_cnt, 1);
    check("stall_n5", n5, 1);
    check("stall_rem_end", {24'd0, remaining}, 0);
    check("stall_tube5", {28'd0, tube5}, 13);

    // ---------------- drain tube5 with 13 fives ----------------
    do_start(8'd65, 1'b0);
    watch_run(300);
    check("d65_timeout", {31'd0, timed_out}, 0);
    check("d65_n5", n5, 13);
    check("d65_tube5", {28'd0, tube5}, 0);
    check("d65_rem", {24'd0, remaining}, 0);

    // ---------------- tube5 empty, amount=10 -> five twos ----------------
    do_start(8'd10, 1'b0);
    watch_run(200);
    check("a10_timeout", {31'd0, timed_out}, 0);
    check("a10_count", ej_cnt, 5);
    check("a10_n2", n2, 5);
    check("a10_rem", {24'd0, remaining}, 0);
    check("a10_tube2", {28'd0, tube2}, 9);

    // ---------------- drain tube2 and most of tube1 ----------------
    do_start(8'd18, 1'b0);
    watch_run(300);
    check("a18_n2", n2, 9);
    check("a18_tube2", {28'd0, tube2}, 0);
    do_start(8'd12, 1'b0);
    watch_run(300);
    check("a12_n1", n1, 12);
    check("a12_tube1", {28'd0, tube1}, 2);

    // ---------------- shortfall ----------------
    do_start(8'd7, 1'b0);
    watch_run(200);
    check("short_timeout", {31'd0, timed_out}, 0);
    check("short_n1", n1, 2);
    check("short_count", ej_cnt, 2);
    check("short_rem", {24'd0, remaining}, 5);
    check("short_flag", {31'd0, short_change}, 1);
    check("short_tubes", {20'd0, tube5, tube2, tube1}, 32'h000);
    repeat (3) @(posedge clk);
    #1;
    check("short_held", {31'd0, short_change}, 1);

    // ---------------- refill with start in same cycle ----------------
    do_start(8'd7, 1'b1);
    check("rf_short_clr", {31'd0, short_change}, 0);
    watch_run(200);
    check("rf_timeout", {31'd0, timed_out}, 0);
    check("rf_count", ej_cnt, 2);
    check("rf_first", {30'd0, ej_log[0]}, 3);
    check("rf_second", {30'd0, ej_log[1]}, 2);
    check("rf_rem", {24'd0, remaining}, 0);
    check("rf_short", {31'd0, short_change}, 0);
    check("rf_tubes", {20'd0, tube5, tube2, tube1}, 32'hEEF);

    // ---------------- reset during EJECT ----------------
    eject_ready = 1'b0;
    do_start(8'd8, 1'b0);
    @(posedge clk); #1;
    check("mid_valid_pre", {31'd0, eject_valid}, 1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_valid", {31'd0, eject_valid}, 0);
    check("mid_denom", {30'd0, eject_denom}, 0);
    check("mid_busy",  {31'd0, busy}, 0);
    check("mid_rem",   {24'd0, remaining}, 0);
    check("mid_tubes", {20'd0, tube5, tube2, tube1}, 32'hFFF);
    @(posedge clk); #1;
    rst = 1'b1;
    eject_ready = 1'b1;
    do_start(8'd8, 1'b0);
    watch_run(200);
    check("post_timeout", {31'd0, timed_out}, 0);
    check("post_count", ej_cnt, 3);
    check("post_first", {30'd0, ej_log[0]}, 3);
    check("post_tubes", {20'd0, tube5, tube2, tube1}, 32'hEEE);

    $display("%0d/%0d checks passed", pass_cnt, chk_total);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Downstream consumer of the controller's change outputs (change_due, change_returning).
- Converts a credit amount into a sequence of physical coin ejections of 5, 2 and 1 units, using a greedy largest-first algorithm.
- Tracks a finite coin tube per denomination and drives a valid/ready handshake to the coin hopper.
- Reports completion and any shortfall to the LED/display logic.

Parameters:
- GAP_CYCLES, default 4: idle cycles enforced between consecutive ejections (min 1).
- TUBE_W, default 4: width of each tube counter.
- TUBE_INIT, default 15: coins per tube after reset or refill (must fit TUBE_W).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset (0 = reset)
- start  input  1  single-cycle request to dispense amount
- amount  input  8  change value in units, sampled when start is accepted
- refill  input  1  single-cycle pulse that loads all tubes with TUBE_INIT
- eject_valid  output  1  an ejection request is pending
- eject_denom  output  2  denomination code: 1=one, 2=two, 3=five, 0=none
- eject_ready  input  1  hopper accepts the ejection
- busy  output  1  high from start acceptance until the done pulse, inclusive
- done  output  1  single-cycle completion pulse
- short_change  output  1  remaining>0 at done; held until the next accepted start
- remaining  output  8  value still owed
- tube5, tube2, tube1  output  TUBE_W each  current tube levels

Behaviour:
- Reset (rst=0, async) values:
  - state IDLE
  - eject_valid=0, eject_denom=0, busy=0, done=0, short_change=0, remaining=0
  - every tube = TUBE_INIT
- FSM states: IDLE, SELECT, EJECT, GAP, FINISH.
- IDLE:
  - start=1 is accepted: remaining<=amount, short_change<=0, busy<=1, go to SELECT.
  - refill=1 loads all tubes; it is honoured only in IDLE and ignored otherwise.
  - start and refill in the same cycle: both take effect; SELECT sees the refilled tubes.
- SELECT: choose the first denomination in the order 5, 2, 1 with value<=remaining and tube>0.
  - If one is found: eject_denom<=code, eject_valid<=1, go to EJECT.
  - If none is found: go to FINISH. This covers remaining=0 and the shortfall case.
- EJECT:
  - eject_valid and eject_denom stay stable until the handshake.
  - Handshake = eject_valid & eject_ready on a clock edge.
  - On handshake: remaining -= value, selected tube -= 1, eject_valid<=0, eject_denom<=0, GAP counter loaded, go to GAP.
  - No timeout; the block waits indefinitely for ready.
- GAP: count GAP_CYCLES cycles, then go to SELECT.
- FINISH:
  - done=1 for exactly one cycle.
  - short_change<=(remaining!=0).
  - busy deasserts the cycle after done.
  - Return to IDLE.
- Latency:
  - start at edge T gives eject_valid high after edge T+1 (SELECT evaluated at T+1).
  - amount=0: done is high for the cycle after edge T+1; zero ejections.
- Ignored inputs:
  - start while busy is ignored; amount is not re-sampled.
  - eject_ready outside EJECT has no effect.
- Arithmetic:
  - remaining never underflows; SELECT guarantees value<=remaining.
  - Tubes never underflow; a tube at 0 is skipped.
  - Tube decrement saturates at 0 as a defensive measure.
- Reset mid-operation: everything returns to reset values immediately. A pending ejection is dropped and tubes revert to TUBE_INIT.
- eject_valid is registered, never combinational from eject_ready.

Decomposition:
- Shared package holds:
  - denomination codes (DENOM_NONE/1/2/5) and their unit values
  - FSM state encoding
  - the code-to-value function
- One natural sub-module: gap_timer. It is a loadable down-counter with a zero flag, reusable by the coin/LED timing blocks.

Test Plan:
- Full tubes, amount=8, eject_ready tied 1 -> ejects 5,2,1 in that order, gap>=GAP_CYCLES between valids, done once, remaining=0, short_change=0, tubes 14/14/14.
- amount=0 -> no eject_valid, done high exactly one cycle after SELECT, busy high 2 cycles.
- tube5 drained to 0 (via three prior amount=5 runs after setting TUBE_INIT=3), amount=10 -> five ejections of denom 2, remaining=0.
- tube5=0, tube2=0, tube1=2, amount=7 -> two ejections of 1, done with remaining=5, short_change=1; refill then amount=7 -> 5,2, short_change cleared.
- amount=5, eject_ready held 0 for 20 cycles with start pulses injected -> eject_valid=1, denom=3 stable throughout, starts ignored; ready=1 -> one transfer, done.
- rst=0 asserted while in EJECT mid-sequence -> outputs at reset values asynchronously, tubes=TUBE_INIT; after release, a new start dispenses normally.
